// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM encoding, opcode legality.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // True for the four opcodes the ALU implements.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// 32-bit ALU: AND/OR/ADD/SUB, modulo 2^32. Unsupported opcodes yield 0.
module alu_core
  import alu_ctrl_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  // Pure combinational operation select.
  always_comb begin
    y_o = 32'd0;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      default: y_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_rr.sv
// Round-robin pick: first asserted request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  int   pos;
  logic found;

  // Scan NUM_REQ positions starting at the pointer; keep the first hit.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[pos]) begin
        gnt_o[pos] = 1'b1;
        idx_o      = ID_W'(pos);
        found      = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters; one operation outstanding at a time.
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; the source holds its payload stable while valid is high and ready is low.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [4*NUM_REQ-1:0]  req_op,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_result,
  output logic                  resp_zero,
  output logic                  resp_err,
  output logic [1:0]            dbg_state
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]        op_q;
  logic [31:0]       a_q, b_q;
  logic [ID_W-1:0]   id_q;
  logic [31:0]       result_q;
  logic              zero_q, err_q;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic [31:0]        alu_y;
  logic               op_legal;
  logic               accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // The single ALU sees only the latched operands.
  alu_core u_alu (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .y_o  (alu_y)
  );

  assign op_legal = is_legal_op(op_q);
  assign accept   = (state_q == IDLE) && gnt_any && rst_n;

  // State and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next state, pointer advance and request-side ready.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (rst_n) req_ready = gnt;
        if (accept) begin
          state_d  = EXEC;
          rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on accept; result capture in EXEC, forced to 0 for bad opcodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= req_op[gnt_idx*4 +: 4];
        a_q  <= req_a[gnt_idx*32 +: 32];
        b_q  <= req_b[gnt_idx*32 +: 32];
        id_q <= gnt_idx;
      end
      if (state_q == EXEC) begin
        result_q <= op_legal ? alu_y : 32'd0;
        zero_q   <= op_legal ? (alu_y == 32'd0) : 1'b1;
        err_q    <= !op_legal;
      end
    end
  end

  assign resp_valid  = (state_q == RESP);
  assign resp_id     = id_q;
  assign resp_result = result_q;
  assign resp_zero   = zero_q;
  assign resp_err    = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with NUM_REQ = 2.
module tb_alu_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [4*NUM_REQ-1:0]  req_op = '0;
  logic [32*NUM_REQ-1:0] req_a = '0;
  logic [32*NUM_REQ-1:0] req_b = '0;
  logic                  resp_valid;
  logic                  resp_ready = 1'b1;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_result;
  logic                  resp_zero;
  logic                  resp_err;
  logic [1:0]            dbg_state;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_err    (resp_err),
    .dbg_state   (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [63:0] exp_q[$];  // {id, result} of granted operations

  typedef struct {
    int          idx;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        e;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid  = '0;
    resp_ready = 1'b1;
    rst_n      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_req(input int idx, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[idx*4 +: 4]  = op;
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
  endtask

  // Single request from requester v.idx; checks accept, latency, response, return to idle.
  task automatic run_vec(input int n, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", n);
    set_req(v.idx, v.op, v.a, v.b);
    req_valid = '0;
    req_valid[v.idx] = 1'b1;
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(1 << v.idx));
    tick();
    req_valid = '0;
    chk({tag, "_exec_valid"}, 32'(resp_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_result"}, resp_result, v.res);
    chk({tag, "_zero"}, 32'(resp_zero), 32'(v.z));
    chk({tag, "_err"}, 32'(resp_err), 32'(v.e));
    chk({tag, "_id"}, 32'(resp_id), 32'(v.idx));
    tick();
    chk({tag, "_done"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [63:0] e;
    int          gid;

    vecs[0] = '{0, 4'b0010, 32'd5,         32'd7,         32'd12,        1'b0, 1'b0};
    vecs[1] = '{0, 4'b0110, 32'h8000_0000, 32'h8000_0000, 32'd0,         1'b1, 1'b0};
    vecs[2] = '{1, 4'b0010, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0};
    vecs[3] = '{1, 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0};
    vecs[4] = '{0, 4'b0001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0};
    vecs[5] = '{1, 4'b0110, 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[6] = '{0, 4'b0011, 32'd3,         32'd4,         32'd0,         1'b1, 1'b1};
    vecs[7] = '{1, 4'b1111, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b1};

    // Reset values, with requests pending while in reset
    req_valid = '1;
    tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_zero", 32'(resp_zero), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    do_reset();

    // Table-driven single operations
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Fairness: both continuously valid, grants alternate 0,1,0,1
    do_reset();
    set_req(0, 4'b0010, 32'd1, 32'd10);
    set_req(1, 4'b0010, 32'd2, 32'd20);
    req_valid = 2'b11;
    #1;
    for (int g = 0; g < 4; g++) begin
      gid = g % 2;
      chk($sformatf("fair%0d_ready", g), 32'(req_ready), 32'(1 << gid));
      exp_q.push_back({32'(gid), (gid == 0) ? 32'd11 : 32'd22});
      tick();
      tick();
      e = exp_q.pop_front();
      chk($sformatf("fair%0d_valid", g), 32'(resp_valid), 32'd1);
      chk($sformatf("fair%0d_id", g), 32'(resp_id), e[63:32]);
      chk($sformatf("fair%0d_result", g), resp_result, e[31:0]);
      tick();
    end
    req_valid = '0;
    tick();

    // Illegal opcode still advances the pointer: next grant goes to requester 1
    do_reset();
    run_vec(8, vecs[6]);
    set_req(1, 4'b0010, 32'd1, 32'd1);
    req_valid = 2'b11;
    #1;
    chk("illegal_ptr_ready", 32'(req_ready), 32'b10);
    tick();
    req_valid = '0;
    tick();
    chk("illegal_ptr_id", 32'(resp_id), 32'd1);
    chk("illegal_ptr_result", resp_result, 32'd2);
    tick();

    // Backpressure: 5 stall cycles in RESP with another requester waiting
    do_reset();
    resp_ready = 1'b0;
    set_req(0, 4'b0010, 32'd5, 32'd7);
    set_req(1, 4'b0000, 32'hFF, 32'h0F);
    req_valid = 2'b01;
    #1;
    chk("bp_ready0", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b10;
    tick();
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("bp%0d_valid", s), 32'(resp_valid), 32'd1);
      chk($sformatf("bp%0d_result", s), resp_result, 32'd12);
      chk($sformatf("bp%0d_id", s), 32'(resp_id), 32'd0);
      chk($sformatf("bp%0d_ready", s), 32'(req_ready), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    chk("bp_release_valid", 32'(resp_valid), 32'd1);
    tick();
    chk("bp_done_valid", 32'(resp_valid), 32'd0);
    chk("bp_next_ready", 32'(req_ready), 32'b10);
    tick();
    req_valid = '0;
    tick();
    chk("bp_next_result", resp_result, 32'h0000_000F);
    chk("bp_next_id", 32'(resp_id), 32'd1);
    tick();

    // Reset during EXEC discards the operation; requester 0 wins afterwards
    do_reset();
    run_vec(9, vecs[0]);
    set_req(1, 4'b0010, 32'd40, 32'd2);
    req_valid = 2'b10;
    #1;
    chk("rexec_ready", 32'(req_ready), 32'b10);
    tick();
    req_valid = 2'b11;
    chk("rexec_state", 32'(dbg_state), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rexec_id", 32'(resp_id), 32'd0);
    chk("rexec_result", resp_result, 32'd0);
    chk("rexec_ready_low", 32'(req_ready), 32'd0);
    chk("rexec_state_idle", 32'(dbg_state), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("rexec_valid%0d", c), 32'(resp_valid), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("rexec_post_ready", 32'(req_ready), 32'b01);
    tick();
    req_valid = '0;
    tick();
    chk("rexec_post_id", 32'(resp_id), 32'd0);
    chk("rexec_post_result", resp_result, 32'd12);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit ALU (AND/OR/ADD/SUB, 4-bit operation code) among NUM_REQ requesters, e.g. an address-generation unit, a branch-compare unit and a debug port. A round-robin arbiter accepts one request at a time with a valid/ready handshake. The block latches the operands, runs them through an internal ALU instance, and returns a registered result tagged with the requester id. Only one operation is outstanding at a time.

## Interface
- NUM_REQ, 2: number of requesters, 2..8.
- ID_W, 1: requester id width, equal to max(1, clog2(NUM_REQ)).
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; assertion takes effect immediately, release is synchronous to clk.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  input  4*NUM_REQ  operation code, slice i for requester i.
- req_a  input  32*NUM_REQ  operand 1, slice i.
- req_b  input  32*NUM_REQ  operand 2, slice i.
- resp_valid  output  1  response valid.
- resp_ready  input  1  response consumer accept.
- resp_id  output  ID_W  index of the requester that issued the operation.
- resp_result  output  32  ALU result.
- resp_zero  output  1  set when resp_result == 0.
- resp_err  output  1  the operation code was unsupported.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE:
  - grant = first asserted req_valid bit searching from rr_ptr upward, with wrap.
  - req_ready[grant] = 1; all other bits 0. With no valid request, req_ready = 0.
  - On the handshake, latch op, a, b and id, then go to EXEC.
  - rr_ptr <= (grant+1) mod NUM_REQ.
- EXEC:
  - The ALU computes on the latched operands.
  - Register result, zero flag and error flag, then go to RESP.
  - req_ready = 0.
- RESP:
  - resp_valid = 1.
  - resp_id, resp_result, resp_zero and resp_err hold stable until resp_valid && resp_ready, then go to IDLE.
  - req_ready = 0.
- Legal opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - Arithmetic is modulo 2^32; no carry or overflow output.
- Any other opcode: the request is still accepted, resp_result = 0, resp_zero = 1, resp_err = 1.
  - The internal ALU result must not be latched for these opcodes.
- Requesters must hold req_op, req_a and req_b stable while req_valid is high and req_ready is low.
  - A requester may drop req_valid before it is granted. Grant is recomputed every IDLE cycle.
- Reset values: state IDLE, rr_ptr 0, resp_valid 0, resp_id 0, resp_result 0, resp_zero 0, resp_err 0.
  - req_ready is 0 while rst_n is low.
- Reset mid-operation (EXEC or RESP): the operation is discarded and no response is issued.
  - The requester is responsible for reissuing it.

## Timing
- Accept in cycle T (the handshake edge). resp_valid rises at edge T+2.
- Minimum occupancy is 3 cycles per operation: accept, EXEC, RESP with resp_ready high.
  - The next accept can occur in the cycle after the response handshake.
- resp_ready held low stalls the block in RESP indefinitely. No request is accepted during the stall.
- req_ready depends combinationally on req_valid and state only. It does not depend on resp_ready.
- Fairness: with all NUM_REQ requesters continuously valid, each requester receives exactly one grant in every NUM_REQ consecutive grants.

## Structure
- Shared package alu_ctrl_pkg contains:
  - opcode constants OP_AND, OP_OR, OP_ADD, OP_SUB;
  - the state encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2;
  - a function is_legal_op.
- The ALU module is instantiated once, driven from the operand registers. The arbiter must not duplicate ALU logic.
- One natural sub-module: rr_arbiter (parameterised NUM_REQ round-robin priority pick, outputs a one-hot grant and its index).

## Test plan
- Single ADD, req 0, a=5, b=7: req_ready[0] high in the accept cycle; resp_valid at T+2 with result 12, zero 0, id 0, err 0.
- SUB a=b=0x8000_0000: result 0, zero 1. ADD 0xFFFF_FFFF+1: result 0, zero 1 (wrap).
- Both requesters valid continuously after reset, resp_ready=1: grant order 0,1,0,1. Responses carry ids 0,1,0,1 with their own operands.
- Backpressure: resp_ready low for 5 cycles in RESP.
  - resp_* stays stable and req_ready stays 0.
  - Response completes on the first resp_ready=1 cycle.
- Opcode 0011 with a=3, b=4: accepted; response has result 0, zero 1, err 1. Arbitration pointer still advances.
- Assert rst_n low during EXEC:
  - resp_valid stays 0; all outputs go to reset values immediately;
  - after release, the first request is granted to requester 0.
